// File: rtl/psram_arb_pkg.sv
// Shared types and sizes for the PSRAM user-port arbiter.
package psram_arb_pkg;
  localparam int ADDR_W      = 21;
  localparam int DATA_W      = 32;
  localparam int BURST_WORDS = 4;
  localparam int BURST_W     = DATA_W * BURST_WORDS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } arb_state_t;

  typedef logic port_idx_t;

  // Word idx of a 4-word burst; word0 sits in the low bits.
  function automatic logic [DATA_W-1:0] burst_word(input logic [BURST_W-1:0] burst,
                                                   input logic [1:0] idx);
    return burst[idx*DATA_W +: DATA_W];
  endfunction
endpackage

// File: rtl/psram_arb_rr.sv
// Two-way round-robin picker: on a tie the port not granted last wins.
module psram_arb_rr
  import psram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  port_idx_t  last,
  output logic [1:0] grant
);

  // One-hot grant from the request pair and the last winner
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/psram_arbiter.sv
// Two-port arbiter and burst-16 command sequencer for the PSRAM user port;
// grants round-robin, streams write words, returns read beats, times out reads.
module psram_arbiter
  import psram_arb_pkg::*;
#(
  parameter int CMD_GAP    = 14,
  parameter int RD_TIMEOUT = 63
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               init_calib,
  input  logic               p0_req,
  input  logic               p0_we,
  input  logic [ADDR_W-1:0]  p0_addr,
  input  logic [BURST_W-1:0] p0_wdata,
  output logic               p0_gnt,
  output logic [DATA_W-1:0]  p0_rdata,
  output logic               p0_rvalid,
  output logic               p0_done,
  output logic               p0_err,
  input  logic               p1_req,
  input  logic               p1_we,
  input  logic [ADDR_W-1:0]  p1_addr,
  input  logic [BURST_W-1:0] p1_wdata,
  output logic               p1_gnt,
  output logic [DATA_W-1:0]  p1_rdata,
  output logic               p1_rvalid,
  output logic               p1_done,
  output logic               p1_err,
  output logic               mem_cmd,
  output logic               mem_cmd_en,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wr_data,
  output logic [3:0]         mem_data_mask,
  input  logic [DATA_W-1:0]  mem_rd_data,
  input  logic               mem_rd_valid,
  output logic               busy
);

  localparam logic [7:0] GAP_LOAD = 8'(CMD_GAP - 1);
  localparam logic [7:0] TMO_LAST = 8'(RD_TIMEOUT - 1);

  arb_state_t         state_r, state_s;
  logic [7:0]         gap_r, gap_s, tcnt_r, tcnt_s;
  logic [1:0]         wcnt_r, wcnt_s, beat_r, beat_s;
  port_idx_t          last_r, last_s, owner_r, owner_s, win_s;
  logic [BURST_W-1:0] wdata_r, wdata_s, sel_wdata_s;
  logic [1:0]         gnt_r, gnt_s, done_r, done_s, err_r, err_s, rvalid_r, rvalid_s;
  logic [1:0]         req_s, rr_grant_s;
  logic               cmd_r, cmd_s, cmd_en_r, cmd_en_s, sel_we_s;
  logic [ADDR_W-1:0]  addr_r, addr_s, sel_addr_s;
  logic [DATA_W-1:0]  wr_data_r, wr_data_s, rdata0_r, rdata0_s, rdata1_r, rdata1_s;

  assign req_s = {p1_req, p0_req};

  psram_arb_rr u_rr (
    .req   (req_s),
    .last  (last_r),
    .grant (rr_grant_s)
  );

  assign win_s       = rr_grant_s[1];
  assign sel_we_s    = win_s ? p1_we    : p0_we;
  assign sel_addr_s  = win_s ? p1_addr  : p0_addr;
  assign sel_wdata_s = win_s ? p1_wdata : p0_wdata;

  // Next-state and next-output logic for the sequencer
  always_comb begin
    state_s   = state_r;
    tcnt_s    = tcnt_r;
    wcnt_s    = wcnt_r;
    beat_s    = beat_r;
    last_s    = last_r;
    owner_s   = owner_r;
    wdata_s   = wdata_r;
    cmd_s     = cmd_r;
    addr_s    = addr_r;
    wr_data_s = wr_data_r;
    rdata0_s  = rdata0_r;
    rdata1_s  = rdata1_r;
    gnt_s     = 2'b00;
    done_s    = 2'b00;
    err_s     = 2'b00;
    rvalid_s  = 2'b00;
    cmd_en_s  = 1'b0;
    if (gap_r != 8'd0) begin
      gap_s = gap_r - 8'd1;
    end else begin
      gap_s = 8'd0;
    end

    case (state_r)
      IDLE: begin
        if ((gap_r == 8'd0) && init_calib && (rr_grant_s != 2'b00)) begin
          gnt_s    = rr_grant_s;
          cmd_en_s = 1'b1;
          cmd_s    = sel_we_s;
          addr_s   = sel_addr_s;
          owner_s  = win_s;
          last_s   = win_s;
          gap_s    = GAP_LOAD;
          if (sel_we_s) begin
            wdata_s   = sel_wdata_s;
            wr_data_s = burst_word(sel_wdata_s, 2'd0);
            wcnt_s    = 2'd1;
            state_s   = WR;
          end else begin
            tcnt_s  = 8'd0;
            beat_s  = 2'd0;
            state_s = RD;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WR: begin
        wr_data_s = burst_word(wdata_r, wcnt_r);
        if (wcnt_r == 2'd3) begin
          done_s[owner_r] = 1'b1;
          state_s         = IDLE;
        end else begin
          wcnt_s = wcnt_r + 2'd1;
        end
      end
      RD: begin
        tcnt_s = tcnt_r + 8'd1;
        if (mem_rd_valid) begin
          rvalid_s[owner_r] = 1'b1;
          beat_s            = beat_r + 2'd1;
          if (owner_r) begin
            rdata1_s = mem_rd_data;
          end else begin
            rdata0_s = mem_rd_data;
          end
        end else begin
          beat_s = beat_r;
        end
        // A 4th beat arriving on the timeout cycle still completes cleanly
        if (mem_rd_valid && (beat_r == 2'd3)) begin
          done_s[owner_r] = 1'b1;
          state_s         = IDLE;
        end else if (tcnt_r == TMO_LAST) begin
          done_s[owner_r] = 1'b1;
          err_s[owner_r]  = 1'b1;
          state_s         = IDLE;
        end else begin
          state_s = RD;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and registered-output flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      gap_r     <= 8'd0;
      tcnt_r    <= 8'd0;
      wcnt_r    <= 2'd0;
      beat_r    <= 2'd0;
      last_r    <= 1'b1;
      owner_r   <= 1'b0;
      wdata_r   <= '0;
      gnt_r     <= 2'b00;
      done_r    <= 2'b00;
      err_r     <= 2'b00;
      rvalid_r  <= 2'b00;
      cmd_r     <= 1'b0;
      cmd_en_r  <= 1'b0;
      addr_r    <= '0;
      wr_data_r <= '0;
      rdata0_r  <= '0;
      rdata1_r  <= '0;
    end else begin
      state_r   <= state_s;
      gap_r     <= gap_s;
      tcnt_r    <= tcnt_s;
      wcnt_r    <= wcnt_s;
      beat_r    <= beat_s;
      last_r    <= last_s;
      owner_r   <= owner_s;
      wdata_r   <= wdata_s;
      gnt_r     <= gnt_s;
      done_r    <= done_s;
      err_r     <= err_s;
      rvalid_r  <= rvalid_s;
      cmd_r     <= cmd_s;
      cmd_en_r  <= cmd_en_s;
      addr_r    <= addr_s;
      wr_data_r <= wr_data_s;
      rdata0_r  <= rdata0_s;
      rdata1_r  <= rdata1_s;
    end
  end

  assign p0_gnt        = gnt_r[0];
  assign p1_gnt        = gnt_r[1];
  assign p0_done       = done_r[0];
  assign p1_done       = done_r[1];
  assign p0_err        = err_r[0];
  assign p1_err        = err_r[1];
  assign p0_rvalid     = rvalid_r[0];
  assign p1_rvalid     = rvalid_r[1];
  assign p0_rdata      = rdata0_r;
  assign p1_rdata      = rdata1_r;
  assign mem_cmd       = cmd_r;
  assign mem_cmd_en    = cmd_en_r;
  assign mem_addr      = addr_r;
  assign mem_wr_data   = wr_data_r;
  assign mem_data_mask = 4'b0000;
  assign busy          = (state_r != IDLE);

endmodule

// File: tb/tb_psram_arbiter.sv
// Directed bench for psram_arbiter with a timestamp-based reference model.
module tb_psram_arbiter;
  localparam int CMD_GAP    = 14;
  localparam int RD_TIMEOUT = 63;

  logic         clk = 1'b0, rst_n = 1'b0, init_calib = 1'b0;
  logic         p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
  logic [20:0]  p0_addr = '0, p1_addr = '0;
  logic [127:0] p0_wdata = '0, p1_wdata = '0;
  logic         p0_gnt, p0_rvalid, p0_done, p0_err, p1_gnt, p1_rvalid, p1_done, p1_err;
  logic [31:0]  p0_rdata, p1_rdata, mem_wr_data;
  logic [31:0]  mem_rd_data = '0;
  logic         mem_rd_valid = 1'b0;
  logic         mem_cmd, mem_cmd_en, busy;
  logic [20:0]  mem_addr;
  logic [3:0]   mem_data_mask;

  psram_arbiter #(.CMD_GAP(CMD_GAP), .RD_TIMEOUT(RD_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .init_calib(init_calib),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rdata(p0_rdata), .p0_rvalid(p0_rvalid), .p0_done(p0_done), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rdata(p1_rdata), .p1_rvalid(p1_rvalid), .p1_done(p1_done), .p1_err(p1_err),
    .mem_cmd(mem_cmd), .mem_cmd_en(mem_cmd_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_data_mask(mem_data_mask), .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int tick = 0;
  always @(posedge clk) tick <= tick + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Memory responder: after a read command, return rd_nbeats beats starting rd_delay cycles later
  int          rd_delay = 10;
  int          rd_nbeats = 4;
  logic [31:0] rd_base = 32'h000000A0;
  initial forever begin
    @(posedge clk); #1;
    if (mem_cmd_en === 1'b1 && mem_cmd === 1'b0) begin
      for (int d = 0; d < rd_delay; d++) begin @(posedge clk); #1; end
      for (int b = 0; b < rd_nbeats; b++) begin
        mem_rd_valid = 1'b1;
        mem_rd_data  = rd_base + 32'(b);
        @(posedge clk); #1;
      end
      mem_rd_valid = 1'b0;
    end
  end

  // Reference model: what each cycle's outputs must be, from inputs of the previous cycle
  int           n = 0, m_owner = 0, m_g = 0, m_beats = 0, m_free = 0, m_lastcmd = -100000, m_last = 1;
  bit           m_active = 1'b0, m_wr = 1'b0;
  logic [127:0] m_words = '0;
  logic [1:0]   pr_req = 2'b00, pr_we = 2'b00;
  logic [20:0]  pr_addr [2];
  logic [127:0] pr_wdata [2];
  logic         pr_calib = 1'b0, pr_rv = 1'b0, pr_rst = 1'b0;
  logic [31:0]  pr_rd = '0;
  logic [1:0]   e_gnt, e_done, e_err, e_rv;
  logic         e_en, e_cmd = 1'b0;
  logic [20:0]  e_addr = '0;
  logic [31:0]  e_wr = '0, e_rd0 = '0, e_rd1 = '0;

  initial begin
    pr_addr[0] = '0; pr_addr[1] = '0; pr_wdata[0] = '0; pr_wdata[1] = '0;
    forever begin
      @(negedge clk);
      n++;
      e_gnt = 2'b00; e_done = 2'b00; e_err = 2'b00; e_rv = 2'b00; e_en = 1'b0;
      if (!rst_n) begin
        e_cmd = 1'b0; e_addr = '0; e_wr = '0; e_rd0 = '0; e_rd1 = '0;
        m_active = 1'b0; m_last = 1; m_free = 0; m_lastcmd = -100000;
      end else begin
        if (m_active && m_wr) begin
          if (n - m_g >= 1 && n - m_g <= 3) e_wr = m_words[(n - m_g)*32 +: 32];
          if (n - m_g == 3) begin e_done[m_owner] = 1'b1; m_active = 1'b0; m_free = n + 1; end
        end else if (m_active) begin
          if (pr_rv) begin
            e_rv[m_owner] = 1'b1;
            if (m_owner == 0) e_rd0 = pr_rd; else e_rd1 = pr_rd;
            m_beats++;
          end
          if (pr_rv && m_beats == 4) begin
            e_done[m_owner] = 1'b1; m_active = 1'b0; m_free = n + 1;
          end else if (n - m_g == RD_TIMEOUT) begin
            e_done[m_owner] = 1'b1; e_err[m_owner] = 1'b1; m_active = 1'b0; m_free = n + 1;
          end
        end
        if (!m_active && n >= m_free && n >= m_lastcmd + CMD_GAP && pr_calib && pr_rst && pr_req != 2'b00) begin
          if (pr_req == 2'b11) m_owner = (m_last == 1) ? 0 : 1;
          else m_owner = pr_req[1] ? 1 : 0;
          e_gnt[m_owner] = 1'b1; e_en = 1'b1;
          e_cmd = pr_we[m_owner]; e_addr = pr_addr[m_owner];
          m_last = m_owner; m_lastcmd = n; m_g = n; m_active = 1'b1; m_beats = 0;
          m_wr = pr_we[m_owner]; m_words = pr_wdata[m_owner];
          if (m_wr) e_wr = m_words[31:0];
        end
      end
      chk("model_pulses",
          128'({p1_gnt, p0_gnt, p1_done, p0_done, p1_err, p0_err, p1_rvalid, p0_rvalid, mem_cmd_en, busy}),
          128'({e_gnt, e_done, e_err, e_rv, e_en, m_active}));
      chk("model_cmd", 128'(mem_cmd), 128'(e_cmd));
      chk("model_addr", 128'(mem_addr), 128'(e_addr));
      chk("model_wr_data", 128'(mem_wr_data), 128'(e_wr));
      chk("model_rdata0", 128'(p0_rdata), 128'(e_rd0));
      chk("model_rdata1", 128'(p1_rdata), 128'(e_rd1));
      chk("model_mask", 128'(mem_data_mask), 128'(4'b0000));
      pr_req = {p1_req, p0_req}; pr_we = {p1_we, p0_we};
      pr_addr[0] = p0_addr; pr_addr[1] = p1_addr;
      pr_wdata[0] = p0_wdata; pr_wdata[1] = p1_wdata;
      pr_calib = init_calib; pr_rv = mem_rd_valid; pr_rd = mem_rd_data; pr_rst = rst_n;
    end
  end

  task automatic wait_gnt(input int port, input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #1;
      if ((port == 0) ? p0_gnt : p1_gnt) begin at = tick; break; end
    end
    chk("gnt_wait", 128'(at >= 0), 128'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Directed stimulus with hand-computed expectations
  initial begin
    int g, g2, d, k, p0rv, cnt, first;
    logic [31:0] w [4];
    logic [1:0]  seq [4];
    int          tk [4];
    w[0] = 32'h11111111; w[1] = 32'h22222222; w[2] = 32'h33333333; w[3] = 32'h44444444;

    repeat (3) @(posedge clk); #1;
    chk("rst_pulses", 128'({p0_gnt, p1_gnt, mem_cmd_en, busy, p0_done, p1_done, p0_rvalid, p1_rvalid}), 128'(0));
    chk("rst_data", 128'({mem_addr, mem_wr_data, p0_rdata, p1_rdata}), 128'(0));
    rst_n = 1'b1;

    // Calibration gating, then a p0 write
    p0_we = 1'b1; p0_addr = 21'h00010; p0_wdata = {w[3], w[2], w[1], w[0]}; p0_req = 1'b1;
    repeat (5) begin @(posedge clk); #1; chk("nocalib_gnt", 128'({p0_gnt, mem_cmd_en}), 128'(2'b00)); end
    init_calib = 1'b1;
    @(posedge clk); #1;
    chk("calib_gnt", 128'({p1_gnt, p0_gnt, mem_cmd_en}), 128'(3'b011));
    chk("calib_cmd", 128'({mem_cmd, mem_addr}), 128'({1'b1, 21'h00010}));
    chk("wr_word0", 128'(mem_wr_data), 128'(w[0]));
    p0_req = 1'b0;
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1;
      chk("wr_word", 128'(mem_wr_data), 128'(w[i]));
      chk("wr_done", 128'(p0_done), 128'(i == 3));
    end

    // p1 read, beats 0xA0..0xA3 ten cycles after the command
    rd_delay = 10; rd_nbeats = 4; rd_base = 32'h000000A0;
    p1_we = 1'b0; p1_addr = 21'h1ABCD; p1_req = 1'b1;
    wait_gnt(1, 60, g);
    p1_req = 1'b0;
    k = 0; p0rv = 0; first = 0;
    for (int i = 0; i < 80 && k < 4; i++) begin
      @(posedge clk); #1;
      if (p0_rvalid) p0rv++;
      if (p1_rvalid) begin
        if (k == 0) first = tick;
        chk("rd_data", 128'(p1_rdata), 128'(32'h000000A0 + 32'(k)));
        chk("rd_done", 128'(p1_done), 128'(k == 3));
        k++;
      end
    end
    chk("rd_beats", 128'(k), 128'(4));
    chk("rd_first_lat", 128'(first - g), 128'(11));
    chk("rd_p0_rvalid", 128'(p0rv), 128'(0));

    // Both ports writing continuously: alternate with a 14-cycle command spacing
    p0_we = 1'b1; p1_we = 1'b1; p1_wdata = {32'hDDDD0003, 32'hDDDD0002, 32'hDDDD0001, 32'hDDDD0000};
    p0_req = 1'b1; p1_req = 1'b1; cnt = 0;
    for (int i = 0; i < 200 && cnt < 4; i++) begin
      @(posedge clk); #1;
      if (p0_gnt || p1_gnt) begin seq[cnt] = {p1_gnt, p0_gnt}; tk[cnt] = tick; cnt++; end
    end
    p0_req = 1'b0; p1_req = 1'b0;
    chk("rr_count", 128'(cnt), 128'(4));
    chk("rr_seq", 128'({seq[0], seq[1], seq[2], seq[3]}), 128'(8'b01_10_01_10));
    for (int i = 0; i < 3; i++) chk("rr_spacing", 128'(tk[i+1] - tk[i]), 128'(CMD_GAP));
    repeat (20) @(posedge clk); #1;

    // Read with only two beats returned: timeout 63 cycles after the command
    rd_delay = 5; rd_nbeats = 2; rd_base = 32'h000000B0;
    p0_we = 1'b0; p0_addr = 21'h00400; p0_req = 1'b1;
    wait_gnt(0, 60, g);
    p0_req = 1'b0; d = -1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (p0_done) begin d = tick; chk("tmo_err", 128'(p0_err), 128'(1)); break; end
    end
    chk("tmo_cycles", 128'(d - g), 128'(RD_TIMEOUT));
    p1_we = 1'b1; p1_addr = 21'h00800; p1_req = 1'b1;
    wait_gnt(1, 40, g2);
    p1_req = 1'b0;
    chk("post_tmo_word0", 128'(mem_wr_data), 128'(32'hDDDD0000));
    repeat (20) @(posedge clk); #1;

    // Reset during word2 of a write; a fresh p1 write afterwards starts at word0
    p1_wdata = {32'hCCCC0003, 32'hCCCC0002, 32'hCCCC0001, 32'hCCCC0000}; p1_req = 1'b1;
    wait_gnt(1, 40, g);
    p1_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_word2", 128'(mem_wr_data), 128'(32'hCCCC0002));
    rst_n = 1'b0; #1;
    chk("mid_rst_pulses", 128'({p0_gnt, p1_gnt, mem_cmd_en, busy, p0_done, p1_done, mem_cmd}), 128'(0));
    chk("mid_rst_data", 128'({mem_addr, mem_wr_data}), 128'(0));
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    p1_wdata = {32'h5A5A0003, 32'h5A5A0002, 32'h5A5A0001, 32'h5A5A0000}; p1_req = 1'b1;
    wait_gnt(1, 40, g);
    p1_req = 1'b0;
    chk("post_rst_word0", 128'(mem_wr_data), 128'(32'h5A5A0000));
    repeat (8) @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
